sdr_port_arbiter: RTL

Round-robin arbiter that shares the single `avalon_sdr` burst engine between `NREQ` requesters (e.g. triangle fetch, ray fetch, framebuffer write). It accepts one read or write command per requester, validates it, issues exactly one start pulse to the engine, waits for the engine's end strobe, and returns a completion pulse to the owner. It sits between the raytracer datapath clients and the `avalon_sdr` external interface, and is the only driver of that interface.

---
 rtl/sdr_pkg.sv | 30 +++
 rtl/rr_pick.sv | 33 +++
 rtl/sdr_port_arbiter.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/sdr_pkg.sv
// Shared types and helpers for the SDR port arbiter: FSM state, engine command payload, command reject check.
package sdr_pkg;

    localparam int unsigned SDR_ADDR_W   = 32;
    localparam int unsigned SDR_NELEMS_W = 30;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } sdr_state_t;

    typedef struct packed {
        logic [SDR_ADDR_W-1:0]   baseaddr;
        logic [SDR_NELEMS_W-1:0] nelems;
    } sdr_cmd_t;

    // Empty transfers and transfers longer than the engine's burst buffer are refused.
    function automatic logic cmd_reject(
        input logic [SDR_NELEMS_W-1:0] nelems,
        input logic                    is_write,
        input logic [SDR_NELEMS_W-1:0] max_rd,
        input logic [SDR_NELEMS_W-1:0] max_wr
    );
        return (nelems == '0) || (nelems > (is_write ? max_wr : max_rd));
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping modulo N.
module rr_pick #(
    parameter int unsigned N  = 3,
    parameter int unsigned IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] idx,
    output logic          valid
);

    int unsigned   pos;
    logic [IW-1:0] pos_i;

    always_comb begin
        idx   = '0;
        valid = 1'b0;
        pos   = 0;
        pos_i = '0;
        for (int unsigned k = 0; k < N; k++) begin
            pos = 32'(ptr) + k;
            if (pos >= N) begin
                pos = pos - N;
            end
            pos_i = IW'(pos);
            if (!valid && req[pos_i]) begin
                idx   = pos_i;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sdr_port_arbiter.sv
// Round-robin arbiter sharing one avalon_sdr burst engine among NREQ requesters; one command in flight.
module sdr_port_arbiter
    import sdr_pkg::*;
#(
    parameter int unsigned NREQ       = 3,
    parameter int unsigned MAX_NREAD  = 64,
    parameter int unsigned MAX_NWRITE = 64
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NREQ-1:0]                    req,
    input  logic [NREQ-1:0]                    req_write,
    input  logic [SDR_ADDR_W*NREQ-1:0]         req_baseaddr,
    input  logic [SDR_NELEMS_W*NREQ-1:0]       req_nelems,
    input  logic [32*MAX_NWRITE*NREQ-1:0]      req_writedata,
    output logic [NREQ-1:0]                    gnt,
    output logic [NREQ-1:0]                    done,
    output logic [NREQ-1:0]                    err,
    output logic [32*MAX_NREAD-1:0]            rd_data,
    output logic [SDR_ADDR_W-1:0]              sdr_baseaddr,
    output logic [SDR_NELEMS_W-1:0]            sdr_nelems,
    output logic [32*MAX_NWRITE-1:0]           sdr_writedata,
    output logic                               sdr_readstart,
    output logic                               sdr_writestart,
    input  logic [32*MAX_NREAD-1:0]            sdr_readdata,
    input  logic                               sdr_readend,
    input  logic                               sdr_writeend
);

    localparam int unsigned IW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned WD_W = 32 * MAX_NWRITE;

    sdr_state_t      state_q, state_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic            is_write_q, is_write_d;
    logic            err_q, err_d;

    logic [IW-1:0]   pick_idx;
    logic            pick_valid;

    logic [NREQ-1:0] gnt_d, done_d, err_o_d;
    sdr_cmd_t        cmd_d;
    logic [WD_W-1:0] writedata_d;
    logic            readstart_d, writestart_d;

    rr_pick #(
        .N  (NREQ),
        .IW (IW)
    ) u_rr_pick (
        .req   (req),
        .ptr   (rr_ptr_q),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    // Engine read data is passed through untouched; the owner samples it in its done cycle.
    assign rd_data = sdr_readdata;

    // Next state, bookkeeping, and next value of every registered output.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        rr_ptr_d     = rr_ptr_q;
        is_write_d   = is_write_q;
        err_d        = err_q;
        gnt_d        = '0;
        done_d       = '0;
        err_o_d      = '0;
        cmd_d        = '0;
        writedata_d  = '0;
        readstart_d  = 1'b0;
        writestart_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    owner_d    = pick_idx;
                    is_write_d = req_write[pick_idx];
                    state_d    = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (cmd_reject(req_nelems[32'(owner_q)*SDR_NELEMS_W +: SDR_NELEMS_W], is_write_q,
                               SDR_NELEMS_W'(MAX_NREAD), SDR_NELEMS_W'(MAX_NWRITE))) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Only the end strobe matching the command direction completes it.
                if (is_write_q ? sdr_writeend : sdr_readend) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                rr_ptr_d = (owner_q == IW'(NREQ - 1)) ? '0 : IW'(owner_q + 1'b1);
                err_d    = 1'b0;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (state_d != ST_IDLE) begin
            gnt_d          = NREQ'(1) << owner_d;
            cmd_d.baseaddr = req_baseaddr[32'(owner_d)*SDR_ADDR_W +: SDR_ADDR_W];
            cmd_d.nelems   = req_nelems[32'(owner_d)*SDR_NELEMS_W +: SDR_NELEMS_W];
            writedata_d    = req_writedata[32'(owner_d)*WD_W +: WD_W];
        end
        if (state_d == ST_ISSUE) begin
            readstart_d  = !is_write_d;
            writestart_d = is_write_d;
        end
        if (state_d == ST_DONE) begin
            done_d = NREQ'(1) << owner_d;
            if (err_d) begin
                err_o_d = NREQ'(1) << owner_d;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            owner_q        <= '0;
            rr_ptr_q       <= '0;
            is_write_q     <= 1'b0;
            err_q          <= 1'b0;
            gnt            <= '0;
            done           <= '0;
            err            <= '0;
            sdr_baseaddr   <= '0;
            sdr_nelems     <= '0;
            sdr_writedata  <= '0;
            sdr_readstart  <= 1'b0;
            sdr_writestart <= 1'b0;
        end else begin
            state_q        <= state_d;
            owner_q        <= owner_d;
            rr_ptr_q       <= rr_ptr_d;
            is_write_q     <= is_write_d;
            err_q          <= err_d;
            gnt            <= gnt_d;
            done           <= done_d;
            err            <= err_o_d;
            sdr_baseaddr   <= cmd_d.baseaddr;
            sdr_nelems     <= cmd_d.nelems;
            sdr_writedata  <= writedata_d;
            sdr_readstart  <= readstart_d;
            sdr_writestart <= writestart_d;
        end
    end

endmodule
